// File: rtl/dout_bus_master_if.sv
// Single-master STB/ACK bus between dout_bus_master and the digital-output port.
// Signal names follow the master's view (o* driven by master, i* driven by slave).
interface dout_bus_if;
    logic [31:0] oADR;
    logic [31:0] oDAT;
    logic [31:0] iDAT;
    logic        oWE;
    logic        oSTB;
    logic        iACK;

    modport master (output oADR, oDAT, oWE, oSTB, input iDAT, iACK);
    modport slave  (input oADR, oDAT, oWE, oSTB, output iDAT, iACK);
endinterface

// File: rtl/dout_bus_master.sv
// Writes three captured bytes to output registers A/B/C over the STB/ACK bus,
// optionally reads them back, and reports busy/done/error status.
module dout_bus_master #(
    parameter logic [31:0] ADDR_A      = 32'h0000_0000,
    parameter logic [31:0] ADDR_B      = 32'h0000_0010,
    parameter logic [31:0] ADDR_C      = 32'h0000_0020,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iSTART,
    input  logic        iVERIFY,
    input  logic [7:0]  iDATA_A,
    input  logic [7:0]  iDATA_B,
    input  logic [7:0]  iDATA_C,
    dout_bus_if.master  bus,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic [1:0]  oERR_CODE
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WSTB = 3'd1;
    localparam logic [2:0] S_RSTB = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]      r_state, w_nstate;
    logic [1:0]      r_idx, w_nidx;
    logic [2:0][7:0] r_data, w_data;
    logic            r_vfy, r_rd, w_nrd;
    logic [7:0]      r_tmo;
    logic            w_start, w_to_err, w_mis_err, w_tmo_hit;
    logic [31:0]     r_adr, r_dat;
    logic            r_we, r_stb, r_busy, r_done, r_err;
    logic [1:0]      r_code;

    function automatic logic [31:0] addr_of(input logic [1:0] idx);
        case (idx)
            2'd0:    addr_of = ADDR_A;
            2'd1:    addr_of = ADDR_B;
            default: addr_of = ADDR_C;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [2:0][7:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = d[0];
            2'd1:    byte_of = d[1];
            default: byte_of = d[2];
        endcase
    endfunction

    // Abort on the edge the count would reach the limit, unless ACK arrives on that edge.
    assign w_tmo_hit = (r_tmo == 8'(ACK_TIMEOUT - 1));

    always_comb begin
        w_nstate  = r_state;
        w_nidx    = r_idx;
        w_nrd     = r_rd;
        w_data    = r_data;
        w_start   = 1'b0;
        w_to_err  = 1'b0;
        w_mis_err = 1'b0;
        case (r_state)
            S_IDLE: if (iSTART) begin
                w_start  = 1'b1;
                w_nstate = S_WSTB;
                w_nidx   = 2'd0;
                w_nrd    = 1'b0;
                w_data   = {iDATA_C, iDATA_B, iDATA_A};
            end
            S_WSTB: begin
                if (bus.iACK)       w_nstate = S_GAP;
                else if (w_tmo_hit) begin w_nstate = S_FIN; w_to_err = 1'b1; end
            end
            S_RSTB: begin
                if (bus.iACK) begin
                    if (bus.iDAT == {24'h0, byte_of(r_data, r_idx)}) w_nstate = S_GAP;
                    else begin w_nstate = S_FIN; w_mis_err = 1'b1; end
                end else if (w_tmo_hit) begin
                    w_nstate = S_FIN;
                    w_to_err = 1'b1;
                end
            end
            S_GAP: begin
                if (r_idx != 2'd2) begin
                    w_nstate = r_rd ? S_RSTB : S_WSTB;
                    w_nidx   = r_idx + 2'd1;
                end else if (!r_rd && r_vfy) begin
                    w_nstate = S_RSTB;
                    w_nidx   = 2'd0;
                    w_nrd    = 1'b1;
                end else begin
                    w_nstate = S_FIN;
                end
            end
            S_FIN:   w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_rd    <= 1'b0;
            r_vfy   <= 1'b0;
            r_data  <= '0;
            r_tmo   <= 8'd0;
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_we    <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_rd    <= w_nrd;
            r_data  <= w_data;
            if (w_start) r_vfy <= iVERIFY;
            r_tmo   <= (r_stb && !bus.iACK) ? r_tmo + 8'd1 : 8'd0;
            r_stb   <= (w_nstate == S_WSTB) || (w_nstate == S_RSTB);
            r_we    <= (w_nstate == S_WSTB);
            r_adr   <= ((w_nstate == S_WSTB) || (w_nstate == S_RSTB)) ? addr_of(w_nidx) : 32'd0;
            r_dat   <= (w_nstate == S_WSTB) ? {24'h0, byte_of(w_data, w_nidx)} : 32'd0;
            r_busy  <= (w_nstate != S_IDLE);
            r_done  <= (w_nstate == S_FIN);
            if (w_start) begin
                r_err  <= 1'b0;
                r_code <= 2'b00;
            end else if (w_to_err) begin
                r_err  <= 1'b1;
                r_code <= 2'b01;
            end else if (w_mis_err) begin
                r_err  <= 1'b1;
                r_code <= 2'b10;
            end
        end
    end

    assign bus.oADR  = r_adr;
    assign bus.oDAT  = r_dat;
    assign bus.oWE   = r_we;
    assign bus.oSTB  = r_stb;
    assign oBUSY     = r_busy;
    assign oDONE     = r_done;
    assign oERR      = r_err;
    assign oERR_CODE = r_code;
endmodule

// File: tb/tb_dout_bus_master.sv
// Bench for dout_bus_master: slave model with programmable latency/corruption,
// per-cycle comparison against a transaction-schedule model.
module tb_dout_bus_master;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, vfy = 1'b0;
    logic [7:0] da = 8'h0, db = 8'h0, dc = 8'h0;
    logic       busy, done, err;
    logic [1:0] code;

    dout_bus_if bus();

    dout_bus_master #(.ACK_TIMEOUT(TO)) dut (
        .iCLK(clk), .iRSTn(rstn), .iSTART(start), .iVERIFY(vfy),
        .iDATA_A(da), .iDATA_B(db), .iDATA_C(dc), .bus(bus),
        .oBUSY(busy), .oDONE(done), .oERR(err), .oERR_CODE(code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Slave: acks after `lat` wait cycles, stores writes, optionally corrupts one read.
    int         lat = 0;
    int         cor = -1;
    bit         nak = 1'b0;
    int         cnt = 0;
    logic [7:0] mem [4];

    always @(posedge clk) begin
        if (bus.oSTB && !bus.iACK) cnt <= cnt + 1;
        else                       cnt <= 0;
        if (bus.oSTB && bus.iACK && bus.oWE) mem[bus.oADR[5:4]] <= bus.oDAT[7:0];
    end

    always_comb begin
        bus.iACK = bus.oSTB && !nak && (cnt == lat);
        bus.iDAT = {24'h0, mem[bus.oADR[5:4]]} ^ ((int'(bus.oADR[5:4]) == cor) ? 32'd1 : 32'd0);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    logic        exp_stb [64];
    logic        exp_we  [64];
    logic [31:0] exp_adr [64];
    logic [31:0] exp_dat [64];

    // One full sequence: build the expected bus schedule, then compare every cycle.
    task automatic run_seq(input logic [7:0] a, b, c, input bit v, input int l,
                           input int co, input bit nk, input bit rep, output int dobs);
        logic [7:0] d [3];
        int ntx, cy, dn, i, len;
        logic [1:0] ecode;
        bit stop, rd;
        d[0] = a; d[1] = b; d[2] = c;
        for (int k = 0; k < 64; k++) begin
            exp_stb[k] = 1'b0; exp_we[k] = 1'b0; exp_adr[k] = 32'd0; exp_dat[k] = 32'd0;
        end
        lat = l; cor = co; nak = nk;
        ntx = v ? 6 : 3; cy = 1; ecode = 2'b00; stop = 1'b0;
        for (int t = 0; t < ntx && !stop; t++) begin
            i   = t % 3;
            rd  = (t >= 3);
            len = (nk && t == 0) ? TO : l + 1;
            for (int j = 0; j < len; j++) begin
                exp_stb[cy+j] = 1'b1;
                exp_we[cy+j]  = !rd;
                exp_adr[cy+j] = 32'h10 * i;
                exp_dat[cy+j] = rd ? 32'd0 : {24'h0, d[i]};
            end
            cy += len;
            if (nk && t == 0)         begin ecode = 2'b01; stop = 1'b1; end
            else if (rd && i == co)   begin ecode = 2'b10; stop = 1'b1; end
            else                      cy += 1;
        end
        dn = cy;

        @(negedge clk);
        start = 1'b1; da = a; db = b; dc = c; vfy = v;
        @(posedge clk);
        dobs = -1;
        for (int k = 1; k <= dn + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom); vfy = 1'($urandom);
            end
            if (rep) start = (k == 4);
            chk("stb",  {31'd0, bus.oSTB}, {31'd0, exp_stb[k]});
            chk("we",   {31'd0, bus.oWE},  {31'd0, exp_we[k]});
            chk("adr",  bus.oADR, exp_adr[k]);
            chk("dat",  bus.oDAT, exp_dat[k]);
            chk("busy", {31'd0, busy}, {31'd0, (k <= dn)});
            chk("done", {31'd0, done}, {31'd0, (k == dn)});
            chk("err",  {31'd0, err},  {31'd0, (k >= dn && ecode != 2'b00)});
            chk("code", {30'd0, code}, (k >= dn) ? {30'd0, ecode} : 32'd0);
            if (done && dobs < 0) dobs = k;
        end
        start = 1'b0;
    endtask

    initial begin
        int d, w;
        bit v;
        #12;
        chk("rst_stb",  {31'd0, bus.oSTB}, 32'd0);
        chk("rst_adr",  bus.oADR, 32'd0);
        chk("rst_dat",  bus.oDAT, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_code", {30'd0, code}, 32'd0);
        @(negedge clk); rstn = 1'b1;

        run_seq(8'h5A, 8'hC3, 8'h0F, 1'b0, 0, -1, 1'b0, 1'b0, d);
        chk("wo_done_cycle", d, 32'd7);
        run_seq(8'h5A, 8'hC3, 8'h0F, 1'b1, 0, -1, 1'b0, 1'b0, d);
        chk("vfy_done_cycle", d, 32'd13);
        run_seq(8'h5A, 8'hC3, 8'h0F, 1'b1, 0, 1, 1'b0, 1'b0, d);
        chk("mis_done_cycle", d, 32'd10);
        run_seq(8'h5A, 8'hC3, 8'h0F, 1'b0, 0, -1, 1'b1, 1'b0, d);
        chk("to_done_cycle", d, 32'd5);
        run_seq(8'h5A, 8'hC3, 8'h0F, 1'b0, 2, -1, 1'b0, 1'b1, d);
        chk("wait_done_cycle", d, 32'd13);

        for (int n = 0; n < 20; n++) begin
            v = 1'($urandom);
            run_seq(8'($urandom), 8'($urandom), 8'($urandom), v, int'($urandom_range(0, 3)),
                    v ? int'($urandom_range(0, 3)) - 1 : -1, ($urandom_range(0, 7) == 0), 1'b0, d);
        end

        // iSTART held high: restart on the first edge back in IDLE.
        lat = 0; nak = 1'b0; cor = -1;
        @(negedge clk); start = 1'b1; vfy = 1'b0; da = 8'h11; db = 8'h22; dc = 8'h33;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) chk("held_done", {31'd0, done}, 32'd1);
            if (k == 8) begin
                chk("held_idle_busy", {31'd0, busy}, 32'd0);
                chk("held_idle_stb",  {31'd0, bus.oSTB}, 32'd0);
            end
            if (k == 9) begin
                chk("held_restart_stb", {31'd0, bus.oSTB}, 32'd1);
                chk("held_restart_adr", bus.oADR, 32'd0);
                chk("held_restart_dat", bus.oDAT, 32'h11);
            end
        end
        start = 1'b0;
        w = 0;
        while (!done && w < 40) begin @(negedge clk); w++; end
        chk("held_second_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a write strobe.
        lat = 3;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("mid_pre_stb", {31'd0, bus.oSTB}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_stb",  {31'd0, bus.oSTB}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_adr",  bus.oADR, 32'd0);
        chk("mid_rst_we",   {31'd0, bus.oWE}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_stb",  {31'd0, bus.oSTB}, 32'd0);
        chk("post_rst_code", {30'd0, code}, 32'd0);

        run_seq(8'hA5, 8'h3C, 8'hF0, 1'b1, 1, -1, 1'b0, 1'b0, d);
        chk("recover_done_cycle", d, 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dout_bus_master.md
Name: dout_bus_master

Overview:
Upstream bus master for the digital-output port. On a start pulse it writes three byte values to the port's A/B/C registers over the single-master STB/ACK bus. It can optionally read them back and compare. It reports done, busy and error status to the controlling logic, such as a test sequencer or a switch-driven controller on the FPGA top level.

Parameters:
ADDR_A, 32'h0000_0000, bus address of output register A
ADDR_B, 32'h0000_0010, bus address of output register B
ADDR_C, 32'h0000_0020, bus address of output register C
ACK_TIMEOUT, 15, consecutive STB-high cycles without ACK before abort (range 1..255)

Ports:
iCLK  in  1  clock, rising edge
iRSTn  in  1  reset, asynchronous, active-low
iSTART  in  1  start request, sampled only in IDLE
iVERIFY  in  1  read-back enable, captured with iSTART
iDATA_A  in  8  value for register A, captured with iSTART
iDATA_B  in  8  value for register B, captured with iSTART
iDATA_C  in  8  value for register C, captured with iSTART
oADR  out  32  bus address
oDAT  out  32  bus write data
iDAT  in  32  bus read data
oWE  out  1  1=write, 0=read; valid only while oSTB=1
oSTB  out  1  transaction request
iACK  in  1  slave acknowledge; may be combinational from oSTB
oBUSY  out  1  high in every state except IDLE
oDONE  out  1  one-cycle pulse when the sequence ends, normally or by abort
oERR  out  1  sticky error flag
oERR_CODE  out  2  00 none, 01 ACK timeout, 10 read-back mismatch

Behaviour:
- Reset (iRSTn=0, asynchronous): state IDLE. All outputs 0, including oADR, oDAT, oERR_CODE and the latched data. The index and timeout counter clear. A reset mid-transaction drops oSTB immediately; no partial completion.
- All outputs are registered. oADR, oDAT and oWE are held stable for the whole time oSTB=1.
- FSM states: IDLE, WSTB, RSTB, GAP, FIN.
- IDLE:
  - iSTART=1 at an edge captures the data bytes and iVERIFY, clears oERR/oERR_CODE and the index, then moves to WSTB.
  - iSTART is ignored in every other state.
- WSTB:
  - oSTB=1, oWE=1, oADR=ADDR_{idx}, oDAT={24'h0, data_idx}.
  - An edge with iACK=1 completes the write and moves to GAP.
- RSTB:
  - oSTB=1, oWE=0, oADR=ADDR_{idx}, oDAT=0.
  - An edge with iACK=1 samples iDAT and compares it against {24'h0, data_idx}.
  - On a match, move to GAP. On a mismatch, set oERR=1, oERR_CODE=10 and move to FIN.
- GAP: oSTB=0, oADR=0, oWE=0. This is a mandatory one-cycle idle between transactions. Next state:
  - WSTB (idx+1) if writes remain.
  - Else RSTB (idx reset to 0) if verify is latched and reads remain.
  - Else FIN.
- FIN: oDONE=1 for exactly one cycle, then IDLE.
- Index order is always A, B, C (idx 0, 1, 2).
- Timeout counter (8-bit):
  - Clears on entering WSTB or RSTB and increments on each STB-high edge with iACK=0.
  - When it reaches ACK_TIMEOUT: drop oSTB, set oERR=1, oERR_CODE=01, go to FIN.
  - If iACK=1 on the same edge the limit is reached, ACK wins and the transaction completes normally.
- Zero-wait slave latency:
  - Write-only: oDONE is high in the 7th cycle after the edge that sampled iSTART.
  - With verify: oDONE is high in the 13th cycle.
  - Each wait cycle on ACK adds one cycle.
- iSTART held high continuously starts a new sequence on the first edge after returning to IDLE.
- oERR and oERR_CODE hold until the next accepted iSTART or reset.
- Input data changes after capture have no effect on the running sequence.

Test Plan:
- Reset mid-write: pulse iRSTn low while oSTB=1 -> oSTB, oBUSY and oDONE go 0 asynchronously; after release the FSM is in IDLE and oERR_CODE=00.
- Write-only, zero-wait slave (ACK=STB):
  - Stimulus: data A/B/C=8'h5A/8'hC3/8'h0F, iVERIFY=0.
  - Required: three single-cycle STB writes to 0x00, 0x10 and 0x20 with oDAT=0x5A, 0xC3, 0x0F, separated by one idle cycle; oDONE pulse at cycle 7; oERR=0.
- Verify pass: same data with iVERIFY=1 and the slave returning stored values -> three writes then three reads to 0x00/0x10/0x20; oDONE at cycle 13; oERR_CODE=00.
- Verify mismatch:
  - Stimulus: slave returns 0x000000C2 for the B read.
  - Required: oERR=1, oERR_CODE=10, no C read issued, oDONE one cycle after the B read.
- ACK timeout, ACK_TIMEOUT=4:
  - Stimulus: slave never acks the first write.
  - Required: oSTB high for exactly 4 cycles, then drops; oERR_CODE=01; oDONE pulse follows; the next iSTART clears oERR.
- Wait states and busy start:
  - Stimulus: slave delays ACK by 2 cycles per transaction; iSTART pulsed again mid-sequence.
  - Required: oDONE at cycle 13 for write-only; the second start is ignored; oADR and oDAT stay stable through the waits.
